// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Shares one combinational ALU between two requesters.
//               Port 0 is typically the execute stage and port 1 the
//               address/branch-compare path. One operation is accepted at a
//               time through a valid/ready handshake with round-robin
//               arbitration. The operands are registered and drive the ALU.
//               The result is captured and returned on the owner's response
//               channel, where it is held under backpressure.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH : operand / result width
//   OP_WIDTH   : operation code width
//   NUM_OPS    : number of legal op codes (codes 0..NUM_OPS-1)
//                ADD=0 SUB=1 XOR=2 OR=3 AND=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9
//
// Ports
//   clk, rst                  : clock (rising edge), synchronous active-high
//                               reset
//   reqN_valid / reqN_ready   : request handshake, N = 0,1
//   reqN_in_1, reqN_in_2      : request operands
//   reqN_op                   : request operation code
//   alu_in_1, alu_in_2, alu_op: registered operands and op driven to the ALU
//   alu_out                   : ALU result (combinational from alu_in_*/op)
//   respN_valid / respN_ready : response handshake, N = 0,1
//   respN_data                : response data (0 when channel not valid)
//   respN_err                 : only with ALU_SHARE_ARBITER_ERR_EN; flags
//                               an illegal op code, qualified by respN_valid
//
// Build option
//   ALU_SHARE_ARBITER_ERR_EN : adds the resp0_err / resp1_err outputs.
//                              Without it an illegal op silently returns 0.
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4,
    parameter int NUM_OPS    = 10
) (
    input  logic                  clk,
    input  logic                  rst,

    // requester 0
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_in_1,
    input  logic [DATA_WIDTH-1:0] req0_in_2,
    input  logic [OP_WIDTH-1:0]   req0_op,

    // requester 1
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_in_1,
    input  logic [DATA_WIDTH-1:0] req1_in_2,
    input  logic [OP_WIDTH-1:0]   req1_op,

    // shared ALU
    output logic [DATA_WIDTH-1:0] alu_in_1,
    output logic [DATA_WIDTH-1:0] alu_in_2,
    output logic [OP_WIDTH-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0] alu_out,

`ifdef ALU_SHARE_ARBITER_ERR_EN
    output logic                  resp0_err,
    output logic                  resp1_err,
`endif

    // response 0
    output logic                  resp0_valid,
    input  logic                  resp0_ready,
    output logic [DATA_WIDTH-1:0] resp0_data,

    // response 1
    output logic                  resp1_valid,
    input  logic                  resp1_ready,
    output logic [DATA_WIDTH-1:0] resp1_data
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle = 2'd0;  // waiting for a request
    localparam logic [1:0] c_st_exec = 2'd1;  // ALU evaluating latched ops
    localparam logic [1:0] c_st_resp = 2'd2;  // result held for the owner

    // Op codes at or above this value are illegal. One extra bit lets
    // NUM_OPS equal 2**OP_WIDTH without overflowing the compare.
    localparam logic [OP_WIDTH:0] c_num_ops = (OP_WIDTH+1)'(NUM_OPS);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic                  r_last_grant;  // owner of the last completed op
    logic                  r_owner;       // port that owns the in-flight op
    logic                  r_invalid;     // latched op code was illegal
    logic [DATA_WIDTH-1:0] r_in_1;
    logic [DATA_WIDTH-1:0] r_in_2;
    logic [OP_WIDTH-1:0]   r_op;
    logic [DATA_WIDTH-1:0] r_result;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [1:0]            w_state_next;
    logic                  w_is_idle;
    logic                  w_is_exec;
    logic                  w_is_resp;
    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_sel_in_1;
    logic [DATA_WIDTH-1:0] w_sel_in_2;
    logic [OP_WIDTH-1:0]   w_sel_op;
    logic                  w_sel_invalid;
    logic                  w_owner_ready;
    logic                  w_resp_fire;

    assign w_is_idle = (r_state == c_st_idle);
    assign w_is_exec = (r_state == c_st_exec);
    assign w_is_resp = (r_state == c_st_resp);

    // ------------------------------------------------------------------------
    // Round-robin grant
    // Port 0 wins a contention unless it owned the previous operation; a
    // lone requester always wins. Grants are masked while rst is high so
    // the ready outputs read 0 during reset even if valid is asserted.
    // ------------------------------------------------------------------------
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (w_is_idle && !rst) begin
            w_grant0 = req0_valid & (~req1_valid | r_last_grant);
            w_grant1 = req1_valid & ~w_grant0;
        end
    end

    assign w_accept = w_grant0 | w_grant1;

    // Operand mux for the granted port; only consulted when w_accept is set.
    always_comb begin
        w_sel_in_1 = req0_in_1;
        w_sel_in_2 = req0_in_2;
        w_sel_op   = req0_op;
        if (w_grant1) begin
            w_sel_in_1 = req1_in_1;
            w_sel_in_2 = req1_in_2;
            w_sel_op   = req1_op;
        end
    end

    assign w_sel_invalid = ({1'b0, w_sel_op} >= c_num_ops);

    // Response handshake on the owner's channel only; a ready on the other
    // channel has no effect.
    assign w_owner_ready = r_owner ? resp1_ready : resp0_ready;
    assign w_resp_fire   = w_is_resp & w_owner_ready;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_next = c_st_exec;
                end
            end
            c_st_exec: begin
                w_state_next = c_st_resp;
            end
            c_st_resp: begin
                if (w_resp_fire) begin
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // The operands are captured only on acceptance. Request inputs that
    // change later cannot disturb the in-flight operation.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_invalid    <= 1'b0;
            r_in_1       <= '0;
            r_in_2       <= '0;
            r_op         <= '0;
            r_result     <= '0;
        end else begin
            if (w_accept) begin
                r_owner   <= w_grant1;
                r_invalid <= w_sel_invalid;
                r_in_1    <= w_sel_in_1;
                r_in_2    <= w_sel_in_2;
                r_op      <= w_sel_op;
            end

            // The ALU sees the registered operands during EXEC; an illegal
            // op produces 0 regardless of what the ALU computes for it.
            if (w_is_exec) begin
                r_result <= r_invalid ? '0 : alu_out;
            end

            if (w_resp_fire) begin
                r_last_grant <= r_owner;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    assign alu_in_1 = r_in_1;
    assign alu_in_2 = r_in_2;
    assign alu_op   = r_op;

    assign resp0_valid = w_is_resp & ~r_owner;
    assign resp1_valid = w_is_resp &  r_owner;

    // Data is forced to zero on the channel that is not presenting a result.
    assign resp0_data = resp0_valid ? r_result : '0;
    assign resp1_data = resp1_valid ? r_result : '0;

`ifdef ALU_SHARE_ARBITER_ERR_EN
    assign resp0_err = resp0_valid & r_invalid;
    assign resp1_err = resp1_valid & r_invalid;
`endif

endmodule

`default_nettype wire
